// File: rtl/cacheline_adapter_if.sv
// Cache-side line request and memory-side burst signals for the cacheline adapter.
// The slave modport is the adapter's view. The master modport is the driver's view (cache plus memory model).
interface cacheline_adapter_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
);
    logic [31:0]             pmem_address;
    logic                    pmem_read;
    logic                    pmem_write;
    logic [LINE_WIDTH-1:0]   pmem_wdata;
    logic [LINE_WIDTH-1:0]   pmem_rdata;
    logic                    pmem_resp;
    logic [31:0]             burst_address;
    logic                    burst_read;
    logic                    burst_write;
    logic [BURST_WIDTH-1:0]  burst_wdata;
    logic [BURST_WIDTH-1:0]  burst_rdata;
    logic                    burst_resp;

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  burst_rdata, burst_resp,
        output pmem_rdata, pmem_resp,
        output burst_address, burst_read, burst_write, burst_wdata
    );

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        output burst_rdata, burst_resp,
        input  pmem_rdata, pmem_resp,
        input  burst_address, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line reads/writebacks into 4-beat 64-bit memory bursts.
// The read line and the writeback line use separate buffers, so a writeback never disturbs pmem_rdata.
module cacheline_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int BEATS       = LINE_WIDTH / BURST_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    cacheline_adapter_if.slave bus
);

    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_accept_write;
    logic                    w_accept_any;
    logic                    w_read_beat;
    logic [LINE_WIDTH-1:0]   r_wbuf;
    logic [LINE_WIDTH-1:0]   r_rbuf;
    logic [31:0]             r_burst_address;
    logic                    r_burst_read;
    logic                    r_burst_write;
    logic                    r_pmem_resp;
    logic [BURST_WIDTH-1:0]  w_burst_wdata;

    // Next-state and beat-counter logic
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_accept_write = 1'b0;
        w_accept_any   = 1'b0;
        w_read_beat    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pmem_write) begin
                    w_accept_write = 1'b1;
                    w_accept_any   = 1'b1;
                    w_state_next   = ST_WRITE;
                end else if (bus.pmem_read) begin
                    w_accept_any   = 1'b1;
                    w_state_next   = ST_READ;
                end else begin
                    w_state_next   = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (bus.burst_resp) begin
                    w_read_beat = (r_state == ST_READ);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next = ST_DONE;
                        w_cnt_next   = {CNT_W{1'b0}};
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and beat counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request capture: address and writeback line are sampled only at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_address <= 32'd0;
            r_wbuf          <= {LINE_WIDTH{1'b0}};
        end else begin
            if (w_accept_any) begin
                r_burst_address <= bus.pmem_address & ADDR_MASK;
            end else begin
                r_burst_address <= r_burst_address;
            end
            if (w_accept_write) begin
                r_wbuf <= bus.pmem_wdata;
            end else begin
                r_wbuf <= r_wbuf;
            end
        end
    end

    // Read line assembly, one beat slot per accepted memory beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rbuf <= {LINE_WIDTH{1'b0}};
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (w_read_beat && (r_cnt == CNT_W'(b))) begin
                    r_rbuf[b*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_rdata;
                end
            end
        end
    end

    // Handshake outputs registered from the next state so they track the state register exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_read  <= 1'b0;
            r_burst_write <= 1'b0;
            r_pmem_resp   <= 1'b0;
        end else begin
            r_burst_read  <= (w_state_next == ST_READ);
            r_burst_write <= (w_state_next == ST_WRITE);
            r_pmem_resp   <= (w_state_next == ST_DONE);
        end
    end

    // Current write beat selected by the counter; zero outside a writeback
    always_comb begin
        w_burst_wdata = {BURST_WIDTH{1'b0}};
        if (r_state == ST_WRITE) begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_cnt == CNT_W'(b)) begin
                    w_burst_wdata = r_wbuf[b*BURST_WIDTH +: BURST_WIDTH];
                end
            end
        end else begin
            w_burst_wdata = {BURST_WIDTH{1'b0}};
        end
    end

    assign bus.burst_address = r_burst_address;
    assign bus.burst_read    = r_burst_read;
    assign bus.burst_write   = r_burst_write;
    assign bus.burst_wdata   = w_burst_wdata;
    assign bus.pmem_resp     = r_pmem_resp;
    assign bus.pmem_rdata    = r_rbuf;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: a cycle-level vector table plus hand sequences for reset and back-to-back cases.
module tb_cacheline_adapter;

    logic clk;
    logic rst;
    cacheline_adapter_if bus ();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [63:0]  brdata;
        logic         bresp;
        logic         e_resp;
        logic         e_brd;
        logic         e_bwr;
        logic [31:0]  e_baddr;
        logic [63:0]  e_bwdata;
        logic [255:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_resp   = 0;

    always @(negedge clk) begin
        if (bus.pmem_resp === 1'b1) n_resp++;
    end

    function automatic logic [63:0] pat(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string nm, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wd, input logic [63:0] brd, input logic br,
                           input logic e_resp, input logic e_brd, input logic e_bwr,
                           input logic [31:0] e_ba, input logic [63:0] e_bwd, input logic [255:0] e_rd);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.brdata = brd; v.bresp = br;
        v.e_resp = e_resp; v.e_brd = e_brd; v.e_bwr = e_bwr; v.e_baddr = e_ba; v.e_bwdata = e_bwd;
        v.e_rdata = e_rd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [63:0] brd, input logic br);
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wd;
        bus.burst_rdata  = brd;
        bus.burst_resp   = br;
    endtask

    task automatic chk_outs(input string nm, input logic e_resp, input logic e_brd, input logic e_bwr,
                            input logic [31:0] e_ba, input logic [63:0] e_bwd, input logic [255:0] e_rd);
        chk({nm, ".pmem_resp"},     256'(bus.pmem_resp),     256'(e_resp));
        chk({nm, ".burst_read"},    256'(bus.burst_read),    256'(e_brd));
        chk({nm, ".burst_write"},   256'(bus.burst_write),   256'(e_bwr));
        chk({nm, ".burst_address"}, 256'(bus.burst_address), 256'(e_ba));
        chk({nm, ".burst_wdata"},   256'(bus.burst_wdata),   256'(e_bwd));
        chk({nm, ".pmem_rdata"},    bus.pmem_rdata,          e_rd);
    endtask

    logic [255:0] line_r;
    logic [255:0] line_d;
    logic [255:0] line_b;
    logic [255:0] line_e;
    logic [255:0] line_f;
    logic [255:0] line_c;
    logic [63:0]  dw[4];
    logic [63:0]  bw[4];
    logic [63:0]  ew[4];
    logic [63:0]  fw[4];
    logic [63:0]  cw[4];
    int           resp_base;

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 256'd0, 64'd0, 1'b0);

        line_r = {pat(8'h44), pat(8'h33), pat(8'h22), pat(8'h11)};
        dw[0] = 64'h0123_4567_89AB_CDEF; dw[1] = 64'hFEDC_BA98_7654_3210;
        dw[2] = 64'hA5A5_5A5A_0F0F_F0F0; dw[3] = 64'h8000_0000_0000_0001;
        line_d = {dw[3], dw[2], dw[1], dw[0]};
        for (int k = 0; k < 4; k++) begin
            bw[k] = pat(8'hB0 + 8'(k));
            ew[k] = pat(8'hE0 + 8'(k));
            fw[k] = pat(8'hF0 + 8'(k));
            cw[k] = pat(8'hC0 + 8'(k));
        end
        line_b = {bw[3], bw[2], bw[1], bw[0]};
        line_e = {ew[3], ew[2], ew[1], ew[0]};
        line_f = {fw[3], fw[2], fw[1], fw[0]};
        line_c = {cw[3], cw[2], cw[1], cw[0]};

        // Read with back-to-back beats; address changes after acceptance must be ignored
        add_vec("rd0", 1'b1, 1'b0, 32'h1234_5678, 256'd0, 64'd0, 1'b0,
                1'b0, 1'b1, 1'b0, 32'h1234_5660, 64'd0, 256'd0);
        add_vec("rd1", 1'b1, 1'b0, 32'hDEAD_BEEF, 256'd0, pat(8'h11), 1'b1,
                1'b0, 1'b1, 1'b0, 32'h1234_5660, 64'd0, {192'd0, pat(8'h11)});
        add_vec("rd2", 1'b1, 1'b0, 32'hDEAD_BEEF, 256'd0, pat(8'h22), 1'b1,
                1'b0, 1'b1, 1'b0, 32'h1234_5660, 64'd0, {128'd0, pat(8'h22), pat(8'h11)});
        add_vec("rd3", 1'b1, 1'b0, 32'hDEAD_BEEF, 256'd0, pat(8'h33), 1'b1,
                1'b0, 1'b1, 1'b0, 32'h1234_5660, 64'd0, {64'd0, pat(8'h33), pat(8'h22), pat(8'h11)});
        add_vec("rd4", 1'b1, 1'b0, 32'hDEAD_BEEF, 256'd0, pat(8'h44), 1'b1,
                1'b1, 1'b0, 1'b0, 32'h1234_5660, 64'd0, line_r);
        add_vec("rd5", 1'b0, 1'b0, 32'hDEAD_BEEF, 256'd0, 64'd0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h1234_5660, 64'd0, line_r);

        // Writeback with two idle cycles before each beat response
        add_vec("wr0", 1'b0, 1'b1, 32'hABCD_EF1F, line_d, 64'd0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'hABCD_EF00, dw[0], line_r);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 2; g++) begin
                add_vec($sformatf("wr_gap%0d_%0d", k, g), 1'b0, 1'b1, 32'd0, 256'd0, 64'd0, 1'b0,
                        1'b0, 1'b0, 1'b1, 32'hABCD_EF00, dw[k], line_r);
            end
            if (k < 3)
                add_vec($sformatf("wr_beat%0d", k), 1'b0, 1'b1, 32'd0, 256'd0, 64'd0, 1'b1,
                        1'b0, 1'b0, 1'b1, 32'hABCD_EF00, dw[k+1], line_r);
            else
                add_vec("wr_last", 1'b0, 1'b1, 32'd0, 256'd0, 64'd0, 1'b1,
                        1'b1, 1'b0, 1'b0, 32'hABCD_EF00, 64'd0, line_r);
        end
        add_vec("wr_idle", 1'b0, 1'b0, 32'd0, 256'd0, 64'd0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'hABCD_EF00, 64'd0, line_r);

        // Read and write together: write wins, burst_read never rises
        add_vec("both0", 1'b1, 1'b1, 32'h0000_0040, line_b, 64'd0, 1'b0,
                1'b0, 1'b0, 1'b1, 32'h0000_0040, bw[0], line_r);
        for (int k = 1; k < 4; k++)
            add_vec($sformatf("both%0d", k), 1'b1, 1'b1, 32'h0000_0040, line_b, pat(8'h99), 1'b1,
                    1'b0, 1'b0, 1'b1, 32'h0000_0040, bw[k], line_r);
        add_vec("both4", 1'b1, 1'b1, 32'h0000_0040, line_b, pat(8'h99), 1'b1,
                1'b1, 1'b0, 1'b0, 32'h0000_0040, 64'd0, line_r);
        add_vec("both5", 1'b0, 1'b0, 32'h0000_0040, 256'd0, 64'd0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h0000_0040, 64'd0, line_r);

        // Reset state
        tick();
        tick();
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 256'd0);
        #3;
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].brdata, vecs[i].bresp);
            tick();
            chk_outs(vecs[i].name, vecs[i].e_resp, vecs[i].e_brd, vecs[i].e_bwr,
                     vecs[i].e_baddr, vecs[i].e_bwdata, vecs[i].e_rdata);
        end

        // Reset in the middle of a read, after two beats
        resp_base = n_resp;
        drive(1'b1, 1'b0, 32'h0000_1040, 256'd0, 64'd0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_1040, 256'd0, pat(8'hA1), 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0000_1040, 256'd0, pat(8'hA2), 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0000_1040, 256'd0, 64'd0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 256'd0);
        tick();
        tick();
        chk_outs("rst_hold", 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 256'd0);
        drive(1'b0, 1'b0, 32'd0, 256'd0, 64'd0, 1'b0);
        #3;
        rst = 1'b1;
        tick();
        chk("rst_no_resp", 256'(n_resp - resp_base), 256'd0);

        // Fresh read after reset starts at beat 0
        drive(1'b1, 1'b0, 32'h0000_2000, 256'd0, 64'd0, 1'b0);
        tick();
        chk_outs("post_rst_acc", 1'b0, 1'b1, 1'b0, 32'h0000_2000, 64'd0, 256'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0000_2000, 256'd0, ew[k], 1'b1);
            tick();
        end
        chk_outs("post_rst_done", 1'b1, 1'b0, 1'b0, 32'h0000_2000, 64'd0, line_e);
        drive(1'b0, 1'b0, 32'd0, 256'd0, 64'd0, 1'b0);
        tick();
        chk_outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 32'h0000_2000, 64'd0, line_e);

        // Stray beat responses while idle change nothing
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0000_5000, 256'd0, pat(8'h77), 1'b1);
            tick();
            chk_outs($sformatf("stray%0d", k), 1'b0, 1'b0, 1'b0, 32'h0000_2000, 64'd0, line_e);
        end

        // Write then read, with the read request held across the write's DONE cycle
        resp_base = n_resp;
        drive(1'b1, 1'b1, 32'h0000_3000, line_f, 64'd0, 1'b0);
        tick();
        chk_outs("wr_rd_acc", 1'b0, 1'b0, 1'b1, 32'h0000_3000, fw[0], line_e);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h0000_3000, line_f, 64'd0, 1'b1);
            tick();
            if (k < 3) chk($sformatf("wr_rd_beat%0d", k), 256'(bus.burst_wdata), 256'(fw[k+1]));
        end
        chk_outs("wr_rd_wdone", 1'b1, 1'b0, 1'b0, 32'h0000_3000, 64'd0, line_e);
        drive(1'b1, 1'b0, 32'h0000_4000, 256'd0, 64'd0, 1'b0);
        tick();
        chk_outs("wr_rd_idle", 1'b0, 1'b0, 1'b0, 32'h0000_3000, 64'd0, line_e);
        tick();
        chk_outs("wr_rd_racc", 1'b0, 1'b1, 1'b0, 32'h0000_4000, 64'd0, line_e);
        tick();
        chk("wr_rd_gap", 256'(bus.burst_read), 256'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 32'h0000_4000, 256'd0, cw[k], 1'b1);
            tick();
        end
        chk_outs("wr_rd_rdone", 1'b1, 1'b0, 1'b0, 32'h0000_4000, 64'd0, line_c);
        drive(1'b0, 1'b0, 32'd0, 256'd0, 64'd0, 1'b0);
        tick();
        tick();
        chk("wr_rd_resp_count", 256'(n_resp - resp_base), 256'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder for the data cache's physical-memory line interface: accepts 256-bit line reads and writebacks from the cache (`pmem_*` signals).
- Converts each line request into a 4-beat, 64-bit burst toward physical memory.
- Buffers the whole line, issues the burst, and completes the cache request with a single-cycle response.
- Sits between the dcache datapath/control and the memory/arbiter port.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, width of one memory beat.
- BEATS, 4, beats per line (LINE_WIDTH/BURST_WIDTH).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- pmem_address  input  32  line address from cache
- pmem_read  input  1  line read request, level, held until pmem_resp
- pmem_write  input  1  line writeback request, level, held until pmem_resp
- pmem_wdata  input  256  writeback line data
- pmem_rdata  output  256  assembled read line
- pmem_resp  output  1  one-cycle completion pulse to cache
- burst_address  output  32  line-aligned burst address
- burst_read  output  1  burst read request, held for whole burst
- burst_write  output  1  burst write request, held for whole burst
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  current read beat
- burst_resp  input  1  memory accepts/returns one beat this cycle

Behaviour:
- Reset (`rst`=0, async):
  - State is IDLE and the beat counter is 0.
  - All outputs are 0; the line buffer is cleared.
  - Reset mid-burst aborts the transaction with no `pmem_resp`. Memory-side cleanup is the arbiter's concern.
- States and transitions:
  - IDLE: latch `{pmem_address[31:5],5'b0}` into `burst_address`.
    - `pmem_write`=1: latch `pmem_wdata` into the line buffer, go to WRITE.
    - Else `pmem_read`=1: go to READ.
    - `pmem_write` has priority if both are asserted.
  - READ: `burst_read`=1.
    - Each cycle with `burst_resp`=1: `buffer[64*cnt +: 64]` <= `burst_rdata`, cnt++.
    - On the beat with cnt==BEATS-1: go to DONE, cnt<=0.
  - WRITE: `burst_write`=1, `burst_wdata` = `buffer[64*cnt +: 64]` (combinational from the counter).
    - Each cycle with `burst_resp`=1: cnt++.
    - Last beat: go to DONE, cnt<=0.
  - DONE: `pmem_resp`=1 for exactly this cycle, then go to IDLE.
- Beat ordering: beat 0 = line bits [63:0], beat 3 = [255:192].
- Gaps: `burst_resp` may have idle cycles between beats; the counter advances only on `burst_resp`.
- Stray inputs: `burst_resp` in IDLE or DONE is ignored; request inputs outside IDLE are ignored. Address and wdata are sampled only at acceptance.
- Outputs in IDLE/DONE:
  - `burst_read`/`burst_write` are 0 in IDLE and DONE.
  - `burst_address` holds its last value.
  - `burst_wdata` is 0 outside WRITE.
- `pmem_rdata` is driven from the line buffer.
  - Valid in DONE after a read; holds until the next read overwrites it.
  - A write does not disturb `pmem_rdata` (separate read register, or the buffer is updated only by reads).
- Back-to-back requests: a request still high in the IDLE cycle after DONE is treated as a new transaction.
- Latency (no memory gaps): request seen in IDLE at edge 0; READ/WRITE on cycles 1–4; `pmem_resp` on cycle 5.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: `pmem_read`=1, `pmem_address`=0x1234_5678; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive `burst_resp`.
  - Required: `burst_address`=0x1234_5660; `pmem_resp` exactly one cycle, 5 cycles after acceptance; `pmem_rdata`={0x44..,0x33..,0x22..,0x11..}.
- Writeback with gaps:
  - Stimulus: `pmem_write`, `pmem_wdata`={D3,D2,D1,D0}, memory inserts 2 idle cycles between beats.
  - Required: `burst_wdata` shows D0,D1,D2,D3 in order, each held until its `burst_resp`; `burst_write` high for the whole burst; single `pmem_resp`.
- Read and write asserted together:
  - Stimulus: both `pmem_read` and `pmem_write` high.
  - Required: WRITE path taken, `burst_read` never asserts.
- Reset mid-read:
  - Stimulus: `rst` low after beat 2.
  - Required: all outputs 0 immediately, no `pmem_resp`.
  - Follow-up: a new read after reset completes normally with cnt starting at beat 0.
- Stray responses:
  - Stimulus: `burst_resp` pulses while IDLE.
  - Required: no state change; a following write then read (read request held across the write's DONE cycle) produces two separate `pmem_resp` pulses and correct data.
